// File: rtl/weight_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : weight_loader_pkg
// Description : Shared types and default sizing for the weight loader.
// Revision    : 1.0 - initial release
// ============================================================================
package weight_loader_pkg;

    localparam int unsigned c_num_words = 784;
    localparam int unsigned c_width     = 32;
    localparam int unsigned c_rd_addr_w = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : weight_loader_pkg
`default_nettype wire

// File: rtl/weight_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : weight_loader_if
// Description : Control, load-stream and read-port bundle of the weight loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface weight_loader_if
    import weight_loader_pkg::*;
#(
    parameter int WIDTH = c_width
);
    logic                   start;
    logic                   s_valid;
    logic [WIDTH-1:0]       s_data;
    logic                   s_last;
    logic                   s_ready;
    logic [c_rd_addr_w-1:0] r_add;
    logic [WIDTH-1:0]       w_out;
    logic                   busy;
    logic                   done;
    logic                   loaded;
    logic                   err;

    modport master (
        output start, s_valid, s_data, s_last, r_add,
        input  s_ready, w_out, busy, done, loaded, err
    );

    modport slave (
        input  start, s_valid, s_data, s_last, r_add,
        output s_ready, w_out, busy, done, loaded, err
    );
endinterface : weight_loader_if
`default_nettype wire

// File: rtl/weight_ram.sv
`default_nettype none
// ============================================================================
// Module      : weight_ram
// Description : Single-write, registered-read storage; read-before-write.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_ram
    import weight_loader_pkg::*;
#(
    parameter int DEPTH  = c_num_words,
    parameter int WIDTH  = c_width,
    parameter int ADDR_W = 10
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_wr_en,
    input  wire logic [ADDR_W-1:0]      i_wr_addr,
    input  wire logic [WIDTH-1:0]       i_wr_data,
    input  wire logic [c_rd_addr_w-1:0] i_rd_addr,
    output      logic [WIDTH-1:0]       o_rd_data
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Storage is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_addr < c_rd_addr_w'(DEPTH)) begin
            r_rd_data <= r_mem[i_rd_addr[ADDR_W-1:0]];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign o_rd_data = r_rd_data;
endmodule : weight_ram
`default_nettype wire

// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
// Module      : weight_loader
// Description : Loads a framed word stream into weight_ram and flags status.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int NUM_WORDS = c_num_words,
    parameter int WIDTH     = c_width
) (
    input wire logic        clk,
    input wire logic        rst,
    weight_loader_if.slave  bus
);
    localparam int                  c_addr_w = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [c_addr_w-1:0] c_last   = c_addr_w'(NUM_WORDS - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [c_addr_w-1:0] r_count;
    logic                r_loaded;
    logic                r_err;
    logic                w_xfer;
    logic                w_at_last;
    logic                w_good_end;
    logic                w_bad_end;
    logic                w_start_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_xfer       = 1'b0;
        w_good_end   = 1'b0;
        w_bad_end    = 1'b0;
        w_start_ok   = 1'b0;
        w_at_last    = (r_count == c_last);
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_start_ok   = 1'b1;
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (bus.s_valid) begin
                    w_xfer = 1'b1;
                    if (w_at_last && bus.s_last) begin
                        w_good_end   = 1'b1;
                        w_next_state = ST_DONE;
                    end else if (w_at_last || bus.s_last) begin
                        // Frame length disagrees with NUM_WORDS in either direction.
                        w_bad_end    = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_loaded <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_count  <= '0;
                r_loaded <= 1'b0;
                r_err    <= 1'b0;
            end
            // The final word ends the load, so the counter is held rather than wrapped.
            if (w_xfer && !w_at_last) begin
                r_count <= r_count + 1'b1;
            end
            if (w_good_end) begin
                r_loaded <= 1'b1;
            end
            if (w_bad_end) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.s_ready = (r_state == ST_LOAD);
    assign bus.busy    = (r_state == ST_LOAD);
    assign bus.done    = (r_state == ST_DONE);
    assign bus.loaded  = r_loaded;
    assign bus.err     = r_err;

    weight_ram #(
        .DEPTH  (NUM_WORDS),
        .WIDTH  (WIDTH),
        .ADDR_W (c_addr_w)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_xfer),
        .i_wr_addr (r_count),
        .i_wr_data (bus.s_data),
        .i_rd_addr (bus.r_add),
        .o_rd_data (bus.w_out)
    );
endmodule : weight_loader
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_loader
// Description : Scenario-driven self-checking bench for weight_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_loader;
    localparam int c_nw = 784;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    weight_loader_if #(.WIDTH(32)) bus ();

    weight_loader #(
        .NUM_WORDS (c_nw),
        .WIDTH     (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [c_nw];
    logic [31:0] sb_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one framed load; observations are returned for the caller to judge.
    task automatic drive_load(input int last_at, input bit toggle, input int abort_at,
                              input int start_at, input int special_idx,
                              input logic [31:0] special_val,
                              output int n_done, output int n_xfer, output bit saw_err,
                              output bit loaded_at_done, output logic [31:0] coll_obs);
        int          i   = 0;
        int          cyc = 0;
        bit          coll;
        logic [31:0] data;
        n_done = 0; n_xfer = 0; saw_err = 1'b0; loaded_at_done = 1'b0; coll_obs = '0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        while (i <= last_at && cyc < 20000) begin
            if (i == abort_at) break;
            bus.start   = (cyc == start_at);
            bus.s_valid = toggle ? (cyc % 2 == 1) : 1'b1;
            data        = (i == special_idx) ? special_val : 32'(i);
            bus.s_data  = data;
            bus.s_last  = (i == last_at);
            coll        = 1'b0;
            if (bus.s_valid && bus.s_ready) begin
                if (i == special_idx) begin
                    bus.r_add = 32'(i);
                    sb_q.push_back(model[i]);
                    coll = 1'b1;
                end
                model[i] = data;
                i++;
                n_xfer++;
            end
            step();
            cyc++;
            if (coll) coll_obs = bus.w_out;
            if (bus.done) begin n_done++; loaded_at_done = bus.loaded; end
            if (bus.err) saw_err = 1'b1;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.start   = 1'b0;
        if (i == abort_at) return;
        repeat (3) begin
            step();
            if (bus.done) begin n_done++; loaded_at_done = bus.loaded; end
            if (bus.err) saw_err = 1'b1;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
        bus.r_add = '0;
        rst = 1'b1;
        repeat (2) step();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
        n_checks++; if (bus.loaded !== 1'b0) begin n_fail++; $display("FAIL reset_loaded got=%0b exp=0", bus.loaded); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0b exp=0", bus.err); end
        n_checks++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready got=%0b exp=0", bus.s_ready); end
        n_checks++; if (bus.w_out !== 32'h0) begin n_fail++; $display("FAIL reset_w_out got=%h exp=0", bus.w_out); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int nd, nx; bit se, ld; logic [31:0] co, exp;
        int addrs [3] = '{0, 500, 783};
        drive_load(c_nw - 1, 1'b0, -1, -1, -1, 32'h0, nd, nx, se, ld, co);
        n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=1", nd); end
        n_checks++; if (nx !== c_nw) begin n_fail++; $display("FAIL b2b_xfers got=%0d exp=%0d", nx, c_nw); end
        n_checks++; if (ld !== 1'b1) begin n_fail++; $display("FAIL b2b_loaded_with_done got=%0b exp=1", ld); end
        n_checks++; if (se !== 1'b0) begin n_fail++; $display("FAIL b2b_err_seen got=%0b exp=0", se); end
        n_checks++; if (bus.loaded !== 1'b1) begin n_fail++; $display("FAIL b2b_loaded_sticky got=%0b exp=1", bus.loaded); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy got=%0b exp=0", bus.busy); end
        foreach (addrs[k]) begin
            bus.r_add = 32'(addrs[k]);
            sb_q.push_back(32'(addrs[k]));
            step();
            exp = sb_q.pop_front();
            n_checks++;
            if (bus.w_out !== exp) begin n_fail++; $display("FAIL b2b_read[%0d] got=%h exp=%h", addrs[k], bus.w_out, exp); end
        end
    endtask

    // Also pulses start mid-load; a disturbed counter shows up in the full readback.
    task automatic test_toggle_valid();
        int nd, nx; bit se, ld; logic [31:0] co, exp;
        drive_load(c_nw - 1, 1'b1, -1, 151, -1, 32'h0, nd, nx, se, ld, co);
        n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL toggle_done_count got=%0d exp=1", nd); end
        n_checks++; if (nx !== c_nw) begin n_fail++; $display("FAIL toggle_xfers got=%0d exp=%0d", nx, c_nw); end
        n_checks++; if (bus.loaded !== 1'b1 || bus.err !== 1'b0) begin
            n_fail++; $display("FAIL toggle_flags got loaded=%0b err=%0b exp loaded=1 err=0", bus.loaded, bus.err);
        end
        for (int a = 0; a < c_nw; a++) begin
            bus.r_add = 32'(a);
            sb_q.push_back(32'(a));
            step();
            exp = sb_q.pop_front();
            n_checks++;
            if (bus.w_out !== exp) begin n_fail++; $display("FAIL toggle_read[%0d] got=%h exp=%h", a, bus.w_out, exp); end
        end
    endtask

    task automatic test_malformed();
        int nd, nx; bit se, ld; logic [31:0] co;
        drive_load(10, 1'b0, -1, -1, -1, 32'h0, nd, nx, se, ld, co);
        n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL short_done_count got=%0d exp=0", nd); end
        n_checks++; if (nx !== 11) begin n_fail++; $display("FAIL short_xfers got=%0d exp=11", nx); end
        n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL short_err got=%0b exp=1", bus.err); end
        n_checks++; if (bus.loaded !== 1'b0) begin n_fail++; $display("FAIL short_loaded got=%0b exp=0", bus.loaded); end
        n_checks++; if (bus.busy !== 1'b0 || bus.s_ready !== 1'b0) begin
            n_fail++; $display("FAIL short_idle got busy=%0b s_ready=%0b exp 0/0", bus.busy, bus.s_ready);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL restart_err_clear got=%0b exp=0", bus.err); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy got=%0b exp=1", bus.busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_load();
        int nd, nx; bit se, ld; logic [31:0] co, exp;
        int addrs [4] = '{0, 299, 300, 783};
        drive_load(c_nw - 1, 1'b0, 300, -1, -1, 32'h0, nd, nx, se, ld, co);
        n_checks++; if (nx !== 300) begin n_fail++; $display("FAIL abort_xfers got=%0d exp=300", nx); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if ({bus.busy, bus.done, bus.loaded, bus.err, bus.s_ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL abort_flags got busy=%0b done=%0b loaded=%0b err=%0b s_ready=%0b exp all 0",
                     bus.busy, bus.done, bus.loaded, bus.err, bus.s_ready);
        end
        n_checks++; if (bus.w_out !== 32'h0) begin n_fail++; $display("FAIL abort_w_out got=%h exp=0", bus.w_out); end
        step();
        drive_load(c_nw - 1, 1'b0, -1, -1, -1, 32'h0, nd, nx, se, ld, co);
        n_checks++; if (nd !== 1 || ld !== 1'b1) begin
            n_fail++; $display("FAIL reload_done got done_count=%0d loaded=%0b exp 1/1", nd, ld);
        end
        foreach (addrs[k]) begin
            bus.r_add = 32'(addrs[k]);
            sb_q.push_back(32'(addrs[k]));
            step();
            exp = sb_q.pop_front();
            n_checks++;
            if (bus.w_out !== exp) begin n_fail++; $display("FAIL reload_read[%0d] got=%h exp=%h", addrs[k], bus.w_out, exp); end
        end
    endtask

    task automatic test_collision();
        int nd, nx; bit se, ld; logic [31:0] co, exp;
        drive_load(c_nw - 1, 1'b0, -1, -1, 5, 32'hAAAA_AAAA, nd, nx, se, ld, co);
        exp = sb_q.pop_front();
        n_checks++; if (co !== exp) begin n_fail++; $display("FAIL rbw_old_data got=%h exp=%h", co, exp); end
        n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL rbw_done_count got=%0d exp=1", nd); end
        bus.r_add = 32'd5;
        sb_q.push_back(32'hAAAA_AAAA);
        step();
        exp = sb_q.pop_front();
        n_checks++; if (bus.w_out !== exp) begin n_fail++; $display("FAIL rbw_new_data got=%h exp=%h", bus.w_out, exp); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] exp;
        logic [31:0] addrs [4] = '{32'd783, 32'd784, 32'd6, 32'hFFFF_FFFF};
        logic [31:0] exps  [4] = '{32'd783, 32'd0,   32'd6, 32'd0};
        foreach (addrs[k]) begin
            bus.r_add = addrs[k];
            sb_q.push_back(exps[k]);
            step();
            exp = sb_q.pop_front();
            n_checks++;
            if (bus.w_out !== exp) begin n_fail++; $display("FAIL oor_read[%h] got=%h exp=%h", addrs[k], bus.w_out, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_toggle_valid();
        test_malformed();
        test_reset_mid_load();
        test_collision();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule : tb_weight_loader
`default_nettype wire
